// File: rtl/sram_port_adapter.sv
// Valid/ready front end for one SRAM read/write port. Reads are captured one cycle
// after issue into a small response FIFO, and requests are credited against free FIFO slots.
module sram_port_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_UNIT  = 8,
  parameter int RESP_DEPTH = 3,
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_UNIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MASK_WIDTH-1:0] req_mask,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MASK_WIDTH-1:0] mem_mask,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [DATA_WIDTH-1:0] store_q [RESP_DEPTH];

  logic          fire;
  logic          push;
  logic          pop;
  logic [CW:0]   used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A slot is reserved for the read still in the SRAM pipeline, so a push never meets a full FIFO.
  assign used       = {1'b0, count_q} + {{CW{1'b0}}, rd_inflight_q};
  assign req_ready  = ~reset & (used < (CW + 1)'(RESP_DEPTH));
  assign fire       = req_valid & req_ready;
  assign push       = rd_inflight_q;
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid & resp_ready;
  assign resp_data  = resp_valid ? store_q[head_q] : '0;

  assign mem_enable = fire;
  assign mem_write  = fire & req_write;
  assign mem_addr   = req_addr;
  assign mem_mask   = req_mask;
  assign mem_dataIn = req_data;

  always_comb begin
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    rd_inflight_d = fire & ~req_write;
    if (push) tail_d = ptr_inc(tail_q);
    if (pop)  head_d = ptr_inc(head_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Storage is left unreset; the empty-FIFO output mux hides stale contents.
  always_ff @(posedge clock) begin
    if (push) store_q[tail_q] <= mem_dataOut;
  end

endmodule

// File: tb/tb_sram_port_adapter.sv
// Directed and random checks of sram_port_adapter against a behavioral masked SRAM
// and a reference memory/response queue.
module tb_sram_port_adapter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MU = 8;
  localparam int MW = DW / MU;
  localparam int RD = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_mask;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          mem_enable, mem_write;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_mask;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;

  sram_port_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_UNIT(MU), .RESP_DEPTH(RD)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_mask(mem_mask), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] sram    [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] exp_q   [$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  pops = 0;
  int  pop_run = 0;
  int  last_pop = -10;
  bit  rand_resp = 0;
  bit  last_en, last_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  // Behavioral SRAM port: masked write, registered read data.
  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_write) begin
        for (int l = 0; l < MW; l++)
          if (mem_mask[l]) sram[mem_addr][l*MU +: MU] = mem_dataIn[l*MU +: MU];
      end else begin
        mem_dataOut <= sram[mem_addr];
      end
    end
  end

  // Scoreboard: reference memory updated at fire, expected responses in request order.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        check("sb_resp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_resp_data", resp_data, exp_q.pop_front());
        pops++;
        pop_run  = (cyc == last_pop + 1) ? pop_run + 1 : 1;
        last_pop = cyc;
      end
      if (req_valid && req_ready) begin
        if (req_write) begin
          for (int l = 0; l < MW; l++)
            if (req_mask[l]) ref_mem[req_addr][l*MU +: MU] = req_data[l*MU +: MU];
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
      if (dut.rd_inflight_q && dut.count_q == RD && !(resp_valid && resp_ready)) begin
        n_errors++;
        $display("FAIL fifo_ovf: push into full FIFO at cycle %0d", cyc);
      end
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (rand_resp) resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [MW-1:0] m,
                       input logic [DW-1:0] d, output bit waited);
    bit rdy;
    rdy = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_mask = m; req_data = d;
    waited = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      rdy = req_ready;
      if (rdy) begin last_en = mem_enable; last_wr = mem_write; end
      @(posedge clock);
      #1;
      if (rdy) return;
      waited = 1'b1;
    end
    check("issue_timeout", rdy, 1);
  endtask

  task automatic wait_resp(input string tag, input logic [DW-1:0] exp);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (resp_valid) begin
        check(tag, resp_data, exp);
        @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
      #1;
    end
    check(tag, resp_valid, 1);
  endtask

  initial begin
    bit w;
    int fires, fires2, p0, nreads;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem_dataOut = '0;
    reset = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = '0; req_mask = '1; req_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    @(posedge clock);
    #1;

    // Write, masked write, then read with latency check
    issue(1, 10'h05, 4'b1111, 32'hDEAD_BEEF, w);
    check("wr_mem_enable", last_en, 1);
    check("wr_mem_write", last_wr, 1);
    issue(1, 10'h05, 4'b0001, 32'h0000_00AA, w);
    issue(0, 10'h05, 4'b0000, 32'h0, w);
    check("rd_mem_write", last_wr, 0);
    req_valid = 1'b0;
    #1;
    check("rd_lat_t1_valid", resp_valid, 0);
    @(posedge clock);
    #1;
    check("rd_lat_t2_valid", resp_valid, 1);
    check("rd_lat_t2_data", resp_data, 32'hDEAD_BEAA);
    idle(3);

    // Back-to-back reads
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      issue(0, AW'(i), '0, '0, w);
      check("b2b_no_stall", w, 0);
    end
    idle(5);
    check("b2b_count", pops - p0, 16);
    check("b2b_consecutive", pop_run, 16);

    // Backpressure
    resp_ready = 1'b0;
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(32 + fires);
      #1;
      if (req_ready) fires++;
      @(posedge clock);
      #1;
    end
    check("bp_accepts", fires, RD);
    check("bp_ready_low", req_ready, 0);
    check("bp_resp_valid", resp_valid, 1);
    check("bp_head_data", resp_data, init_val(32));
    @(posedge clock);
    #1;
    check("bp_head_stable", resp_data, init_val(32));
    resp_ready = 1'b1;
    fires2 = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(32 + fires + fires2);
      #1;
      if (req_ready) fires2++;
      @(posedge clock);
      #1;
    end
    check("bp_resume", fires2, 9);
    idle(5);
    check("bp_drained", exp_q.size(), 0);
    check("bp_idle_valid", resp_valid, 0);

    // Zero-mask write
    issue(1, 10'h40, 4'b1111, 32'h1234_5678, w);
    issue(1, 10'h40, 4'b0000, 32'hFFFF_FFFF, w);
    check("zm_mem_enable", last_en, 1);
    check("zm_mem_write", last_wr, 1);
    req_valid = 1'b0;
    #1;
    check("zm_enable_pulse", mem_enable, 0);
    issue(0, 10'h40, '0, '0, w);
    req_valid = 1'b0;
    wait_resp("zm_read", 32'h1234_5678);
    idle(2);

    // Mid-operation reset
    resp_ready = 1'b0;
    issue(0, 10'h41, '0, '0, w);
    issue(0, 10'h42, '0, '0, w);
    req_valid = 1'b0;
    #1;
    check("mr_pre_valid", resp_valid, 1);
    check("mr_pre_inflight", dut.rd_inflight_q, 1);
    reset = 1'b1;
    #1;
    check("mr_ready_in_reset", req_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("mr_resp_valid", resp_valid, 0);
    check("mr_count", dut.count_q, 0);
    check("mr_ready", req_ready, 1);
    resp_ready = 1'b1;
    p0 = pops;
    idle(3);
    check("mr_no_stale_valid", resp_valid, 0);
    check("mr_no_stale_pops", pops - p0, 0);
    issue(0, 10'h43, '0, '0, w);
    req_valid = 1'b0;
    wait_resp("mr_next_read", init_val(32'h43));
    idle(2);

    // Random traffic with random backpressure
    p0 = pops;
    nreads = 0;
    rand_resp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bit wr;
      wr = ($urandom_range(0, 2) == 0);
      if (!wr) nreads++;
      issue(wr, AW'($urandom_range(0, 31)), MW'($urandom), DW'($urandom), w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    req_valid = 1'b0;
    rand_resp = 1'b0;
    idle(1);
    resp_ready = 1'b1;
    idle(12);
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_resp_valid", resp_valid, 0);
    check("rnd_resp_count", pops - p0, nreads);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
